frame_loader: RTL

// - Upstream stage of the motion-estimation pipeline; feeds the estimator's R/S memories and start.
// - Accepts a byte stream and writes 256 reference-block bytes into R memory.
// - Then writes 1024 search-window bytes (32x32, row-major) into S memory.
// - Then raises start to the control unit, holds it until completed, and releases it for the next frame.

---
 rtl/me_pkg.sv | 20 ++
 rtl/frame_loader_if.sv | 52 +++++
 rtl/frame_loader.sv | 116 +++++++++++
 3 files changed

// File: rtl/me_pkg.sv
// Shared motion-estimation package: loader FSM states and frame geometry.
// Reused by the frame loader, control unit and result-capture stages.
package me_pkg;

   localparam int DW      = 8;
   localparam int R_DEPTH = 256;
   localparam int S_DEPTH = 1024;
   localparam int S_ROW   = 32;
   localparam int BLK     = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_R,
      LOAD_S,
      FLUSH,
      RUN,
      DONE
   } loader_state_t;

endpackage

// File: rtl/frame_loader_if.sv
// Frame loader bus: pixel stream, R/S memory write ports, start/completed.
// FRAME_LOADER_CHECKSUM_EN adds the 16-bit frame checksum signal.
interface frame_loader_if;
   import me_pkg::*;

   logic          load_go;
   logic          pix_valid;
   logic [DW-1:0] pix_data;
   logic          pix_ready;
   logic          r_we;
   logic [7:0]    r_addr;
   logic [DW-1:0] r_wdata;
   logic          s_we;
   logic [9:0]    s_addr;
   logic [DW-1:0] s_wdata;
   logic          start;
   logic          completed;
   logic          busy;
   logic          frame_done;
`ifdef FRAME_LOADER_CHECKSUM_EN
   logic [15:0]   checksum;

   modport slave (
      input  load_go, pix_valid, pix_data, completed,
      output pix_ready, r_we, r_addr, r_wdata,
      output s_we, s_addr, s_wdata,
      output start, busy, frame_done, checksum
   );

   modport master (
      output load_go, pix_valid, pix_data, completed,
      input  pix_ready, r_we, r_addr, r_wdata,
      input  s_we, s_addr, s_wdata,
      input  start, busy, frame_done, checksum
   );
`else
   modport slave (
      input  load_go, pix_valid, pix_data, completed,
      output pix_ready, r_we, r_addr, r_wdata,
      output s_we, s_addr, s_wdata,
      output start, busy, frame_done
   );

   modport master (
      output load_go, pix_valid, pix_data, completed,
      input  pix_ready, r_we, r_addr, r_wdata,
      input  s_we, s_addr, s_wdata,
      input  start, busy, frame_done
   );
`endif

endinterface

// File: rtl/frame_loader.sv
// Frame loader: streams 256 R bytes then 1024 S bytes, then runs the search.
// FRAME_LOADER_CHECKSUM_EN adds a mod-2^16 sum of all accepted bytes.
module frame_loader
   import me_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   frame_loader_if.slave  bus
);

   loader_state_t state_q, state_d;
   logic [9:0]    idx_q, idx_d;
   logic          r_we_q, r_we_d;
   logic          s_we_q, s_we_d;
   logic [9:0]    addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          ld;
   logic          accept;
   logic          last_r;
   logic          last_s;

   assign ld     = (state_q == LOAD_R) || (state_q == LOAD_S);
   assign accept = bus.pix_valid & ld;
   assign last_r = idx_q == 10'(R_DEPTH - 1);
   assign last_s = idx_q == 10'(S_DEPTH - 1);

   // Next state and index counter; index wraps to 0 on the R->S switch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (bus.load_go) begin
               state_d = LOAD_R;
               idx_d   = '0;
            end
         end
         LOAD_R: begin
            if (accept) begin
               idx_d = last_r ? 10'd0 : idx_q + 10'd1;
               if (last_r) state_d = LOAD_S;
            end
         end
         LOAD_S: begin
            if (accept) begin
               idx_d = idx_q + 10'd1;
               if (last_s) state_d = FLUSH;
            end
         end
         FLUSH: state_d = RUN;
         RUN: begin
            if (bus.completed) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered write port: one strobe per accepted byte, one cycle later.
   always_comb begin
      r_we_d  = accept & (state_q == LOAD_R);
      s_we_d  = accept & (state_q == LOAD_S);
      addr_d  = accept ? idx_q : addr_q;
      wdata_d = accept ? bus.pix_data : wdata_q;
   end

   // State, counter and write-port registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         r_we_q  <= 1'b0;
         s_we_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         r_we_q  <= r_we_d;
         s_we_q  <= s_we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.pix_ready  = ld;
   assign bus.r_we       = r_we_q;
   assign bus.r_addr     = addr_q[7:0];
   assign bus.r_wdata    = wdata_q;
   assign bus.s_we       = s_we_q;
   assign bus.s_addr     = addr_q;
   assign bus.s_wdata    = wdata_q;
   assign bus.start      = state_q == RUN;
   assign bus.busy       = state_q != IDLE;
   assign bus.frame_done = state_q == DONE;

`ifdef FRAME_LOADER_CHECKSUM_EN
   logic [15:0] csum_q, csum_d;

   // Running sum, cleared on frame start; frozen once loading ends.
   always_comb begin
      csum_d = csum_q;
      if ((state_q == IDLE) && bus.load_go) csum_d = '0;
      else if (accept) csum_d = csum_q + 16'(bus.pix_data);
   end

   // Checksum register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) csum_q <= '0;
      else        csum_q <= csum_d;
   end

   assign bus.checksum = csum_q;
`endif

endmodule
